// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: walks an external key expander through the rounds
// and keeps every round key in a local file that the round datapath reads.
module key_schedule_ctrl #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] cipher_key,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [3:0]       rk_rd_addr,
    output logic [KEY_W-1:0] rk_rd_data,
    output logic             kx_load_en,
    output logic [KEY_W-1:0] kx_key_in,
    output logic [31:0]      kx_rcon,
    input  logic [KEY_W-1:0] kx_key_out
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    // Storage is always sized for the full AES-128 schedule; reduced-round builds
    // simply leave the upper entries at zero.
    localparam int         RK_N = 11;
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    state_t           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             keys_valid_q, keys_valid_d;
    logic [KEY_W-1:0] rk_q [RK_N];
    logic [KEY_W-1:0] rk_d [RK_N];

    function automatic logic [7:0] rc_lut(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        rk_d         = rk_q;
        if (clear) begin
            // Abort leaves the stored keys in place but marks them unusable.
            state_d      = IDLE;
            round_d      = 4'd0;
            busy_d       = 1'b0;
            keys_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rk_d[0]      = cipher_key;
                        round_d      = 4'd1;
                        keys_valid_d = 1'b0;
                        busy_d       = 1'b1;
                        state_d      = LOAD;
                    end
                end
                LOAD: state_d = WAIT;
                WAIT: begin
                    rk_d[round_q] = kx_key_out;
                    if (round_q == LAST) begin
                        state_d      = IDLE;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        keys_valid_d = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            round_q      <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            for (int i = 0; i < RK_N; i++) rk_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            rk_q         <= rk_d;
        end
    end

    // Expander drive is decoded from state so it is quiet outside LOAD.
    always_comb begin
        kx_load_en = 1'b0;
        kx_key_in  = '0;
        kx_rcon    = '0;
        if (state_q == LOAD) begin
            kx_load_en = 1'b1;
            kx_key_in  = rk_q[round_q - 4'd1];
            kx_rcon    = {rc_lut(round_q), 24'h0};
        end
    end

    always_comb begin
        rk_rd_data = '0;
        if (rk_rd_addr <= LAST) rk_rd_data = rk_q[rk_rd_addr];
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;

endmodule
